// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed 7-segment scanner with frame-aligned digit latching
// Optional feature: define LZ_BLANK_EN to blank leading zeros (positions above 0 that are zero with no dp).
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic                    slot_end;
    logic                    frame_tick;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   idx_onehot;
    logic [NUM_DIGITS-1:0]   lz_mask;

    // Hex-digit to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    // Slot and frame boundary detection; frame_tick only counts while scanning.
    always_comb begin
        slot_end   = (refresh_cnt == CNT_LAST);
        frame_tick = enable && slot_end && (digit_idx == IDX_LAST);
    end

    // Refresh counter and digit index; disabling parks the scan at digit 0, slot start.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (slot_end) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Pending/active double buffer: active only changes at frame edges (or while idle)
    // so a frame never mixes old and new digits. A load on the frame edge bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
            end
            if (load && (!enable || frame_tick)) begin
                act_digits <= digits_in;
                act_dp     <= dp_in;
            end else if (frame_tick) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
            end
        end
    end

    // Leading-zero mask: a position is blank when it and every higher position are zero with no dp.
`ifdef LZ_BLANK_EN
    always_comb begin
        logic tail_zero;
        tail_zero = 1'b1;
        lz_mask   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            tail_zero  = tail_zero && (act_digits[4*k +: 4] == 4'd0) && !act_dp[k];
            lz_mask[k] = tail_zero && (k != 0);
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    // Select the digit, dp and blanking flag for the position currently being scanned.
    always_comb begin
        cur_digit  = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        idx_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_digit     = act_digits[4*k +: 4];
                cur_dp        = act_dp[k];
                cur_blank     = lz_mask[k];
                idx_onehot[k] = 1'b1;
            end
        end
    end

    // Registered pin drivers; blank whenever reset, disabled, or the position is suppressed.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_tick;
            if (cur_blank) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~idx_onehot;
                seg <= seg_decode(cur_digit);
                dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           load;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_done;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: position within the frame as a single cycle count, plus the two buffers.
    int             m_pos     = 0;
    logic [4*N-1:0] m_pend_d  = '0;
    logic [N-1:0]   m_pend_dp = '0;
    logic [4*N-1:0] m_act_d   = '0;
    logic [N-1:0]   m_act_dp  = '0;

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic lz_blank(input int d);
`ifdef LZ_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < N; j++) begin
            if (m_act_d[4*j +: 4] != 4'd0 || m_act_dp[j]) return 1'b0;
        end
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    task automatic drive(input logic r, input logic en, input logic ld,
                         input logic [4*N-1:0] d, input logic [N-1:0] p);
        exp_t e;
        int   dig;
        bit   boundary;
        reset     = r;
        enable    = en;
        load      = ld;
        digits_in = d;
        dp_in     = p;
        e.an  = '1;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
        if (r) begin
            m_pos     = 0;
            m_pend_d  = '0;
            m_pend_dp = '0;
            m_act_d   = '0;
            m_act_dp  = '0;
        end else if (!en) begin
            m_pos = 0;
            if (ld) begin
                m_pend_d  = d;
                m_pend_dp = p;
                m_act_d   = d;
                m_act_dp  = p;
            end
        end else begin
            dig      = m_pos / RD;
            boundary = (m_pos == FRAME - 1);
            if (!lz_blank(dig)) begin
                e.an  = ~(4'(1) << dig);
                e.seg = SEG_TAB[m_act_d[4*dig +: 4]];
                e.dp  = ~m_act_dp[dig];
            end
            e.fd = boundary;
            if (boundary) begin
                m_act_d  = ld ? d : m_pend_d;
                m_act_dp = ld ? p : m_pend_dp;
            end
            if (ld) begin
                m_pend_d  = d;
                m_pend_dp = p;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * FRAME && m_pos != target; i++) idle(1);
    endtask

    // Monitor: one registered output set per clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL queue_empty at %0t: actual an=%h seg=%h, required a queued expectation", $time, an, seg);
            end else begin
                e = exp_q.pop_front();
                if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                    miscompares++;
                    $display("FAIL outputs at %0t: actual an=%h seg=%h dp=%b fd=%b, required an=%h seg=%h dp=%b fd=%b",
                             $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        logic [4*N-1:0] rd;
        logic [N-1:0]   rp;
        // Reset held, load ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 16'h7777, 4'hF);
        // Load on first enabled cycle, run past two frame boundaries.
        drive(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0000);
        idle(2 * FRAME + 8);
        // Dash, dp and leading zeros.
        drive(1'b0, 1'b1, 1'b1, 16'h00A5, 4'b0010);
        idle(2 * FRAME + 4);
        // Load mid-frame (digit-1 slot) waits for the boundary.
        wait_pos(RD + 1);
        drive(1'b0, 1'b1, 1'b1, 16'h9999, 4'b0000);
        idle(FRAME + 4);
        // Load exactly on the boundary edge bypasses pending.
        wait_pos(FRAME - 1);
        drive(1'b0, 1'b1, 1'b1, 16'h5555, 4'b1000);
        idle(FRAME + 2);
        // Drop enable mid digit-2, then re-enable.
        wait_pos(2 * RD + 1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 4);
        // Load while disabled takes effect immediately.
        drive(1'b0, 1'b0, 1'b1, 16'h0300, 4'b0000);
        idle(FRAME);
        // Reset wins over a coincident load.
        wait_pos(RD + 2);
        drive(1'b1, 1'b1, 1'b1, 16'h8888, 4'hF);
        idle(FRAME + 4);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                rd[4*k +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) != 0),
                  ($urandom_range(0, 5) == 0), rd, rp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
